// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch, data port and debug loader.
// One access in flight; DM > IF > DBG priority, with DBG promoted after STARVE_MAX waiting cycles.
module unified_mem_arbiter #(
  parameter int DATA_W     = 19,
  parameter int ADDR_W     = 12,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;
  localparam int SC_W  = 4;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_DM = 2'd2, OWN_DBG = 2'd3} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            sel_s;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              rd_done_s;
  logic              issue_ok_s;
  logic              promote_s;

  // State, owner, latency and starvation registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= {CNT_W{1'b0}};
      starve_cnt_q <= {SC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Winner selection, RAM mux, read return and next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = {SC_W{1'b0}};
    sel_s        = OWN_NONE;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    dbg_gnt      = 1'b0;
    if_rvalid    = 1'b0;
    dm_rvalid    = 1'b0;
    dbg_rvalid   = 1'b0;
    if_rdata     = {DATA_W{1'b0}};
    dm_rdata     = {DATA_W{1'b0}};
    dbg_rdata    = {DATA_W{1'b0}};
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = {ADDR_W{1'b0}};
    ram_wdata    = {DATA_W{1'b0}};
    busy         = (state_q == S_WAIT);

    rd_done_s  = (state_q == S_WAIT) && (lat_cnt_q == {CNT_W{1'b0}});
    // Gating with reset keeps grants low while reset is asserted, not just after the next edge.
    issue_ok_s = reset && ((state_q == S_IDLE) || rd_done_s);
    promote_s  = (starve_cnt_q == SC_W'(STARVE_MAX));

    if (issue_ok_s) begin
      if (dbg_req && promote_s) begin
        sel_s = OWN_DBG;
      end else if (dm_req) begin
        sel_s = OWN_DM;
      end else if (if_req) begin
        sel_s = OWN_IF;
      end else if (dbg_req) begin
        sel_s = OWN_DBG;
      end else begin
        sel_s = OWN_NONE;
      end
    end else begin
      sel_s = OWN_NONE;
    end

    case (sel_s)
      OWN_IF: begin
        if_gnt   = 1'b1;
        ram_en   = 1'b1;
        ram_addr = if_addr;
      end
      OWN_DM: begin
        dm_gnt    = 1'b1;
        ram_en    = 1'b1;
        ram_we    = dm_we;
        ram_addr  = dm_addr;
        ram_wdata = dm_wdata;
      end
      OWN_DBG: begin
        dbg_gnt   = 1'b1;
        ram_en    = 1'b1;
        ram_we    = dbg_we;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase

    if (rd_done_s) begin
      case (owner_q)
        OWN_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = ram_rdata;
        end
        OWN_DM: begin
          dm_rvalid = 1'b1;
          dm_rdata  = ram_rdata;
        end
        OWN_DBG: begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = ram_rdata;
        end
        default: begin
          if_rvalid = 1'b0;
        end
      endcase
      state_d = S_IDLE;
      owner_d = OWN_NONE;
    end else if (state_q == S_WAIT) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
    end else begin
      lat_cnt_d = lat_cnt_q;
    end

    if (ram_en && !ram_we) begin
      state_d   = S_WAIT;
      owner_d   = sel_s;
      lat_cnt_d = CNT_W'(MEM_LAT - 1);
    end else begin
      state_d = state_d;
    end

    if (dbg_req && !dbg_gnt) begin
      if (promote_s) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else begin
      starve_cnt_d = {SC_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one DUT at MEM_LAT=2, one at MEM_LAT=1, each with its own RAM model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [11:0] if_addr = 12'h0, dm_addr = 12'h0, dbg_addr = 12'h0;
  logic [18:0] dm_wdata = 19'h0, dbg_wdata = 19'h0;

  logic        if_gnt2, if_rvalid2, dm_gnt2, dm_rvalid2, dbg_gnt2, dbg_rvalid2, ram_en2, ram_we2, busy2;
  logic [18:0] if_rdata2, dm_rdata2, dbg_rdata2, ram_wdata2, ram_rdata2;
  logic [11:0] ram_addr2;
  logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, dbg_gnt1, dbg_rvalid1, ram_en1, ram_we1, busy1;
  logic [18:0] if_rdata1, dm_rdata1, dbg_rdata1, ram_wdata1, ram_rdata1;
  logic [11:0] ram_addr1;

  int checks = 0;
  int errors = 0;

  logic [18:0] mem2 [0:4095];
  logic [18:0] mem1 [0:4095];
  logic [18:0] p2a, p2b, p1a;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.DATA_W(19), .ADDR_W(12), .MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2), .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt2), .dbg_rvalid(dbg_rvalid2), .dbg_rdata(dbg_rdata2),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2), .busy(busy2)
  );

  unified_mem_arbiter #(.DATA_W(19), .ADDR_W(12), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .busy(busy1)
  );

  // RAM models: contents default to {7'h55, addr}; read data appears MEM_LAT cycles after ram_en
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4096; i++) begin
        mem2[i] <= {7'h55, i[11:0]};
        mem1[i] <= {7'h55, i[11:0]};
      end
    end else begin
      if (ram_en2 && ram_we2) mem2[ram_addr2] <= ram_wdata2;
      if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_wdata1;
    end
    if (ram_en2 && !ram_we2) p2a <= mem2[ram_addr2];
    p2b <= p2a;
    if (ram_en1 && !ram_we1) p1a <= mem1[ram_addr1];
  end
  assign ram_rdata2 = p2b;
  assign ram_rdata1 = p1a;

  task automatic clear_inputs();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    if_addr = 12'h0; dm_addr = 12'h0; dbg_addr = 12'h0; dm_wdata = 19'h0; dbg_wdata = 19'h0;
  endtask

  // Leaves time at posedge+1 with reset released, ready to drive T0 inputs
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    if_req = 1'b1; if_addr = 12'h010; dm_req = 1'b1; dbg_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({if_gnt2, dm_gnt2, dbg_gnt2, ram_en2, ram_we2, busy2} !== 6'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 000000", {if_gnt2, dm_gnt2, dbg_gnt2, ram_en2, ram_we2, busy2}); end
    checks++; if ({if_rvalid2, dm_rvalid2, dbg_rvalid2} !== 3'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 000", {if_rvalid2, dm_rvalid2, dbg_rvalid2}); end
    checks++; if ({if_rdata2, dm_rdata2, dbg_rdata2, ram_wdata2, ram_addr2} !== 88'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {if_rdata2, dm_rdata2, dbg_rdata2, ram_wdata2, ram_addr2}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    checks++; if ({if_gnt2, ram_en2, ram_we2, busy2} !== 4'b1100) begin errors++; $display("FAIL t1_issue got %b exp 1100", {if_gnt2, ram_en2, ram_we2, busy2}); end
    checks++; if (ram_addr2 !== 12'h010) begin errors++; $display("FAIL t1_addr got %h exp 010", ram_addr2); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_gnt2, if_rvalid2, ram_en2, busy2} !== 4'b0001) begin errors++; $display("FAIL t1_T1 got %b exp 0001", {if_gnt2, if_rvalid2, ram_en2, busy2}); end
    @(negedge clk);
    checks++; if ({if_rvalid2, busy2} !== 2'b11) begin errors++; $display("FAIL t1_T2 got %b exp 11", {if_rvalid2, busy2}); end
    checks++; if (if_rdata2 !== 19'h55010) begin errors++; $display("FAIL t1_rdata got %h exp 55010", if_rdata2); end
    @(negedge clk);
    checks++; if ({if_rvalid2, busy2, if_rdata2} !== 21'h0) begin errors++; $display("FAIL t1_T3 got %h exp 0", {if_rvalid2, busy2, if_rdata2}); end
  endtask

  task automatic test_priority();
    do_reset();
    if_req = 1'b1; if_addr = 12'h010; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200;
    @(negedge clk);
    checks++; if ({dm_gnt2, if_gnt2, dbg_gnt2} !== 3'b100) begin errors++; $display("FAIL t2_T0 got %b exp 100", {dm_gnt2, if_gnt2, dbg_gnt2}); end
    checks++; if (ram_addr2 !== 12'h200) begin errors++; $display("FAIL t2_addr got %h exp 200", ram_addr2); end
    @(posedge clk); #1 dm_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_gnt2, ram_en2, busy2} !== 3'b001) begin errors++; $display("FAIL t2_T1 got %b exp 001", {if_gnt2, ram_en2, busy2}); end
    @(negedge clk);
    checks++; if ({dm_rvalid2, if_rvalid2, if_gnt2} !== 3'b101) begin errors++; $display("FAIL t2_T2 got %b exp 101", {dm_rvalid2, if_rvalid2, if_gnt2}); end
    checks++; if (dm_rdata2 !== 19'h55200) begin errors++; $display("FAIL t2_dmdata got %h exp 55200", dm_rdata2); end
    checks++; if (ram_addr2 !== 12'h010) begin errors++; $display("FAIL t2_ifaddr got %h exp 010", ram_addr2); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_rvalid2 !== 1'b0) begin errors++; $display("FAIL t2_T3 got %b exp 0", if_rvalid2); end
    @(negedge clk);
    checks++; if ({if_rvalid2, dm_rvalid2} !== 2'b10) begin errors++; $display("FAIL t2_T4 got %b exp 10", {if_rvalid2, dm_rvalid2}); end
    checks++; if (if_rdata2 !== 19'h55010) begin errors++; $display("FAIL t2_ifdata got %h exp 55010", if_rdata2); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h005; dm_wdata = 19'h7FFFF;
    @(negedge clk);
    checks++; if ({dm_gnt2, ram_en2, ram_we2} !== 3'b111) begin errors++; $display("FAIL t3_wr got %b exp 111", {dm_gnt2, ram_en2, ram_we2}); end
    checks++; if (ram_wdata2 !== 19'h7FFFF) begin errors++; $display("FAIL t3_wdata got %h exp 7ffff", ram_wdata2); end
    @(posedge clk); #1 dm_we = 1'b0;
    @(negedge clk);
    checks++; if ({dm_gnt2, ram_en2, ram_we2, busy2} !== 4'b1100) begin errors++; $display("FAIL t3_rd got %b exp 1100", {dm_gnt2, ram_en2, ram_we2, busy2}); end
    @(posedge clk); #1 dm_req = 1'b0;
    @(negedge clk);
    checks++; if ({dm_rvalid2, ram_we2} !== 2'b00) begin errors++; $display("FAIL t3_T2 got %b exp 00", {dm_rvalid2, ram_we2}); end
    @(negedge clk);
    checks++; if ({dm_rvalid2, dm_rdata2} !== {1'b1, 19'h7FFFF}) begin errors++; $display("FAIL t3_T3 got %b/%h exp 1/7ffff", dm_rvalid2, dm_rdata2); end
  endtask

  task automatic test_starvation();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h100; dm_wdata = 19'h00001;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h300; dbg_wdata = 19'h00002;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if ({dm_gnt2, dbg_gnt2} !== 2'b10) begin errors++; $display("FAIL t4_c%0d got %b exp 10", c, {dm_gnt2, dbg_gnt2}); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if ({dm_gnt2, dbg_gnt2} !== 2'b01) begin errors++; $display("FAIL t4_c5 got %b exp 01", {dm_gnt2, dbg_gnt2}); end
    checks++; if ({ram_addr2, ram_wdata2} !== {12'h300, 19'h00002}) begin errors++; $display("FAIL t4_mux got %h/%h exp 300/00002", ram_addr2, ram_wdata2); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({dm_gnt2, dbg_gnt2} !== 2'b10) begin errors++; $display("FAIL t4_c6 got %b exp 10", {dm_gnt2, dbg_gnt2}); end
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    if_req = 1'b1; if_addr = 12'h010;
    @(negedge clk);
    checks++; if (if_gnt2 !== 1'b1) begin errors++; $display("FAIL t5_issue got %b exp 1", if_gnt2); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL t5_busy got %b exp 1", busy2); end
    reset = 1'b0; if_req = 1'b1; if_addr = 12'h020;
    #1;
    checks++; if ({busy2, if_gnt2, ram_en2, if_rvalid2} !== 4'b0000) begin errors++; $display("FAIL t5_async got %b exp 0000", {busy2, if_gnt2, ram_en2, if_rvalid2}); end
    @(posedge clk); #1;
    checks++; if ({if_rvalid2, busy2} !== 2'b00) begin errors++; $display("FAIL t5_norv got %b exp 00", {if_rvalid2, busy2}); end
    @(negedge clk); #1 reset = 1'b1;
    #1;
    checks++; if ({if_gnt2, ram_addr2} !== {1'b1, 12'h020}) begin errors++; $display("FAIL t5_regnt got %b/%h exp 1/020", if_gnt2, ram_addr2); end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_rvalid2 !== 1'b0) begin errors++; $display("FAIL t5_R1 got %b exp 0", if_rvalid2); end
    @(negedge clk);
    checks++; if ({if_rvalid2, if_rdata2} !== {1'b1, 19'h55020}) begin errors++; $display("FAIL t5_R2 got %b/%h exp 1/55020", if_rvalid2, if_rdata2); end
  endtask

  task automatic test_back_to_back_lat1();
    logic [11:0] prev_addr;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if_req = 1'b1; if_addr = 12'h040 + 12'(k);
      @(negedge clk);
      checks++; if (if_gnt1 !== 1'b1) begin errors++; $display("FAIL t6_gnt%0d got %b exp 1", k, if_gnt1); end
      if (k == 0) begin
        checks++; if (if_rvalid1 !== 1'b0) begin errors++; $display("FAIL t6_rv0 got %b exp 0", if_rvalid1); end
      end else begin
        prev_addr = 12'h040 + 12'(k - 1);
        checks++; if ({if_rvalid1, if_rdata1} !== {1'b1, 7'h55, prev_addr}) begin errors++; $display("FAIL t6_rv%0d got %b/%h exp 1/%h", k, if_rvalid1, if_rdata1, {7'h55, prev_addr}); end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_write_then_read();
    test_starvation();
    test_async_reset();
    test_back_to_back_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
